// File: rtl/oled_cursor_scheduler.sv
// oled_cursor_scheduler: scales PS/2 mouse positions onto the OLED panel,
// double-buffers cursor position and mode at frame boundaries, and answers
// per-pixel colour requests with a registered RGB565 value.
`timescale 1ns/1ps

module oled_cursor_scheduler #(
  parameter int unsigned WIDTH   = 96,
  parameter int unsigned HEIGHT  = 64,
  parameter int unsigned MOUSE_W = 960,
  parameter int unsigned MOUSE_H = 640,
  parameter logic [15:0] COL_BOX = 16'h07E0,
  parameter logic [15:0] COL_DOT = 16'hF800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        middle,
  input  logic        new_event,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  output logic [15:0] pixel_data,
  output logic [6:0]  cursor_x,
  output logic [5:0]  cursor_y,
  output logic        mode,
  output logic        busy
);

  localparam int unsigned POS_W   = 12;
  localparam int unsigned PROD_W  = 19;
  localparam int unsigned IDX_W   = 13;
  localparam int unsigned CX_W    = 7;
  localparam int unsigned CY_W    = 6;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned ITERS   = PROD_W;
  localparam int unsigned DIV_MAX = (MOUSE_W > MOUSE_H) ? MOUSE_W : MOUSE_H;
  localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);

  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [POS_W-1:0]   x_cap;
  logic [POS_W-1:0]   y_cap;
  logic [PROD_W-1:0]  quo;
  logic [DIV_W-1:0]   rem;
  logic [CX_W-1:0]    xs;
  logic [CY_W-1:0]    ys;
  logic               restart;

  logic [CX_W-1:0]    shadow_x;
  logic [CY_W-1:0]    shadow_y;
  logic               shadow_valid;
  logic               shadow_mode;
  logic               middle_q;

  // One restoring-divider step shared by both axes
  logic [DIV_W-1:0]   divisor;
  logic [DIV_W:0]     rem_shift;
  logic               rem_ge;
  logic [DIV_W-1:0]   rem_next;
  logic [PROD_W-1:0]  quo_next;
  logic [PROD_W-1:0]  x_prod;
  logic [PROD_W-1:0]  y_prod;
  logic [CX_W-1:0]    xs_clamp;
  logic [CY_W-1:0]    ys_clamp;

  // Divider datapath: shift one dividend bit into the remainder per cycle
  always_comb begin
    divisor   = (state == CALC_Y) ? DIV_W'(MOUSE_H) : DIV_W'(MOUSE_W);
    rem_shift = {rem, quo[PROD_W-1]};
    rem_ge    = (rem_shift >= {1'b0, divisor});
    rem_next  = rem_ge ? DIV_W'(rem_shift - {1'b0, divisor}) : DIV_W'(rem_shift);
    quo_next  = {quo[PROD_W-2:0], rem_ge};
    x_prod    = PROD_W'(x_cap) * PROD_W'(WIDTH);
    y_prod    = PROD_W'(y_cap) * PROD_W'(HEIGHT);
    xs_clamp  = (quo_next > PROD_W'(WIDTH - 1))  ? CX_W'(WIDTH - 1)  : CX_W'(quo_next);
    ys_clamp  = (quo_next > PROD_W'(HEIGHT - 1)) ? CY_W'(HEIGHT - 1) : CY_W'(quo_next);
  end

  // Scaling FSM: capture, divide x, divide y, publish; one pending restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      x_cap   <= '0;
      y_cap   <= '0;
      quo     <= '0;
      rem     <= '0;
      xs      <= '0;
      ys      <= '0;
      restart <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (new_event) begin
            x_cap <= xpos;
            y_cap <= ypos;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC_X;
          end
        end
        CALC_X, CALC_Y: begin
          if (new_event) restart <= 1'b1;
          if (cnt == '0) begin
            quo <= (state == CALC_X) ? x_prod : y_prod;
            rem <= '0;
            cnt <= CNT_W'(1);
          end else begin
            quo <= quo_next;
            rem <= rem_next;
            if (cnt == CNT_W'(ITERS)) begin
              cnt <= '0;
              if (state == CALC_X) begin
                xs    <= xs_clamp;
                state <= CALC_Y;
              end else begin
                ys    <= ys_clamp;
                state <= DONE;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          // Latest position wins: recapture live inputs on a pending event
          if (restart || new_event) begin
            x_cap   <= xpos;
            y_cap   <= ypos;
            restart <= 1'b0;
            cnt     <= '0;
            state   <= CALC_X;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Shadow buffer, mode toggle, and frame-boundary commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_x     <= '0;
      shadow_y     <= '0;
      shadow_valid <= 1'b0;
      shadow_mode  <= 1'b0;
      middle_q     <= 1'b0;
      cursor_x     <= '0;
      cursor_y     <= '0;
      mode         <= 1'b0;
    end else begin
      middle_q <= middle;
      if (middle && !middle_q) shadow_mode <= ~shadow_mode;
      if (frame_begin) begin
        mode <= shadow_mode;
        if (shadow_valid) begin
          cursor_x <= shadow_x;
          cursor_y <= shadow_y;
        end
        shadow_valid <= 1'b0;
      end
      // A fresh result in the commit cycle survives to the next frame
      if (state == DONE) begin
        shadow_x     <= xs;
        shadow_y     <= ys;
        shadow_valid <= 1'b1;
      end
    end
  end

  // Pixel coordinates and cursor hit tests, widened to avoid underflow
  logic [PIX_W-1:0] px;
  logic [PIX_W-1:0] py;
  logic [PIX_W-1:0] cx;
  logic [PIX_W-1:0] cy;
  logic             in_range;
  logic             hit_dot;
  logic             hit_box;

  always_comb begin
    px       = PIX_W'(pixel_index % IDX_W'(WIDTH));
    py       = PIX_W'(pixel_index / IDX_W'(WIDTH));
    cx       = PIX_W'(cursor_x);
    cy       = PIX_W'(cursor_y);
    in_range = (pixel_index < IDX_W'(WIDTH * HEIGHT));
    hit_dot  = (px == cx) && (py == cy);
    hit_box  = (px + PIX_W'(1) >= cx) && (px <= cx + PIX_W'(1)) &&
               (py + PIX_W'(1) >= cy) && (py <= cy + PIX_W'(1));
  end

  // Registered colour for the requested pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_data <= '0;
    end else if (!in_range) begin
      pixel_data <= '0;
    end else if (mode) begin
      pixel_data <= hit_dot ? COL_DOT : 16'h0000;
    end else begin
      pixel_data <= hit_box ? COL_BOX : 16'h0000;
    end
  end

endmodule

// File: tb/tb_oled_cursor_scheduler.sv
// Bench for oled_cursor_scheduler: directed stimulus with a queue-based
// scoreboard checked by an independent monitor on the falling edge.
`timescale 1ns/1ps

module tb_oled_cursor_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic        middle = 1'b0;
  logic        new_event = 1'b0;
  logic        frame_begin = 1'b0;
  logic [12:0] pixel_index = '0;
  logic [15:0] pixel_data;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic        mode;
  logic        busy;

  always #5 clk = ~clk;

  oled_cursor_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .xpos        (xpos),
    .ypos        (ypos),
    .middle      (middle),
    .new_event   (new_event),
    .frame_begin (frame_begin),
    .pixel_index (pixel_index),
    .pixel_data  (pixel_data),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .mode        (mode),
    .busy        (busy)
  );

  localparam logic [15:0] GRN = 16'h07E0;
  localparam logic [15:0] RED = 16'hF800;

  // sel: 0 cursor_x, 1 cursor_y, 2 mode, 3 busy, 4 pixel_data
  typedef struct {
    int          sel;
    logic [15:0] exp;
  } chk_t;

  chk_t        sq[$];
  logic [15:0] pq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          stat_n  = 0;
  logic        pix_req = 1'b0;
  logic        pix_valid = 1'b0;

  function automatic logic [15:0] dut_val(int sel);
    case (sel)
      0:       return 16'(cursor_x);
      1:       return 16'(cursor_y);
      2:       return 16'(mode);
      3:       return 16'(busy);
      default: return pixel_data;
    endcase
  endfunction

  function automatic string sel_name(int sel);
    case (sel)
      0:       return "cursor_x";
      1:       return "cursor_y";
      2:       return "mode";
      3:       return "busy";
      default: return "pixel_data";
    endcase
  endfunction

  // A pixel request becomes observable one clock later
  always @(posedge clk) pix_valid <= pix_req;

  // Monitor: pops expectations whenever the DUT presents a checked output
  always @(negedge clk) begin
    chk_t        e;
    logic [15:0] act;
    logic [15:0] pexp;
    for (int i = 0; i < stat_n; i++) begin
      n_tests++;
      if (sq.size() == 0) begin
        n_fail++;
        $display("FAIL status_queue_empty at %0t", $time);
      end else begin
        e   = sq.pop_front();
        act = dut_val(e.sel);
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h at %0t", sel_name(e.sel), act, e.exp, $time);
        end
      end
    end
    if (pix_valid) begin
      n_tests++;
      if (pq.size() == 0) begin
        n_fail++;
        $display("FAIL pixel_queue_empty at %0t", $time);
      end else begin
        pexp = pq.pop_front();
        if (pixel_data !== pexp) begin
          n_fail++;
          $display("FAIL pixel_data: got %h expected %h at %0t", pixel_data, pexp, $time);
        end
      end
    end
  end

  // Advance one cycle; pulses default low
  task automatic step();
    @(posedge clk);
    #1;
    stat_n      = 0;
    pix_req     = 1'b0;
    new_event   = 1'b0;
    frame_begin = 1'b0;
  endtask

  task automatic expect_sig(input int sel, input logic [15:0] v);
    chk_t e;
    e.sel = sel;
    e.exp = v;
    sq.push_back(e);
    stat_n++;
  endtask

  task automatic expect_pos(input logic [6:0] cx, input logic [5:0] cy,
                            input logic md, input logic bz);
    expect_sig(0, 16'(cx));
    expect_sig(1, 16'(cy));
    expect_sig(2, 16'(md));
    expect_sig(3, 16'(bz));
  endtask

  task automatic pix(input logic [12:0] idx, input logic [15:0] v);
    step();
    pixel_index = idx;
    pq.push_back(v);
    pix_req = 1'b1;
  endtask

  // Issue an event, wait (bounded) for the divider to finish, then commit
  task automatic event_and_commit(input logic [11:0] x, input logic [11:0] y);
    int k;
    step();
    xpos = x;
    ypos = y;
    new_event = 1'b1;
    step();
    k = 0;
    while (busy !== 1'b0 && k < 200) begin
      step();
      k++;
    end
    n_tests++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, k);
    end
    step();
    frame_begin = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      step();
      xpos        = 12'($urandom);
      ypos        = 12'($urandom);
      middle      = 1'($urandom);
      new_event   = 1'($urandom);
      frame_begin = 1'($urandom);
      pixel_index = 13'($urandom);
      expect_pos(7'd0, 6'd0, 1'b0, 1'b0);
      expect_sig(4, 16'h0000);
    end
    step();
    rst_n = 1'b1;
    middle = 1'b0;
    xpos = '0;
    ypos = '0;
    pixel_index = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      frame_begin = 1'b1;
      step();
      expect_pos(7'd0, 6'd0, 1'b0, 1'b0);
    end

    // Scaling and exact busy window; early frame_begin commits nothing
    step();
    xpos = 12'd475;
    ypos = 12'd312;
    new_event = 1'b1;
    expect_sig(3, 16'd0);
    for (int c = 1; c <= 42; c++) begin
      step();
      expect_sig(3, (c <= 41) ? 16'd1 : 16'd0);
      if (c == 20) frame_begin = 1'b1;
      if (c == 21) begin
        expect_sig(0, 16'd0);
        expect_sig(1, 16'd0);
      end
    end
    step();
    frame_begin = 1'b1;
    step();
    expect_pos(7'd47, 6'd31, 1'b0, 1'b0);

    // Box pixels around (47,31)
    pix(13'd3120, GRN);
    pix(13'd3072, 16'h0000);
    pix(13'd3022, GRN);
    pix(13'd3025, 16'h0000);
    pix(13'd2927, GRN);
    pix(13'd2831, 16'h0000);

    // Mode toggle commits only at the next frame
    step();
    middle = 1'b1;
    step();
    middle = 1'b0;
    expect_sig(2, 16'd0);
    step();
    frame_begin = 1'b1;
    step();
    expect_sig(2, 16'd1);
    pix(13'd3023, RED);
    pix(13'd3024, 16'h0000);
    pix(13'd3022, 16'h0000);

    // Toggle in the commit cycle is deferred one frame
    step();
    middle = 1'b1;
    frame_begin = 1'b1;
    step();
    middle = 1'b0;
    expect_sig(2, 16'd1);
    step();
    frame_begin = 1'b1;
    step();
    expect_sig(2, 16'd0);

    // Clamp to the far corner and clip the box there
    event_and_commit(12'd2000, 12'd4000);
    expect_pos(7'd95, 6'd63, 1'b0, 1'b0);
    pix(13'd6142, GRN);
    pix(13'd6143, GRN);
    pix(13'd6047, GRN);
    pix(13'd6045, 16'h0000);
    pix(13'd6144, 16'h0000);
    pix(13'd8191, 16'h0000);

    // Origin: box clipped without wrap
    event_and_commit(12'd0, 12'd0);
    expect_pos(7'd0, 6'd0, 1'b0, 1'b0);
    pix(13'd0, GRN);
    pix(13'd1, GRN);
    pix(13'd96, GRN);
    pix(13'd95, 16'h0000);
    pix(13'd191, 16'h0000);
    pix(13'd6143, 16'h0000);
    pix(13'd193, 16'h0000);

    // Overlapping events: first result publishes, restart recomputes latest
    step();
    xpos = 12'd100;
    ypos = 12'd100;
    new_event = 1'b1;
    for (int c = 1; c <= 84; c++) begin
      step();
      if (c == 10) begin
        xpos = 12'd300;
        ypos = 12'd200;
        new_event = 1'b1;
      end
      if (c == 12) new_event = 1'b1;
      if (c == 41 || c == 42 || c == 82) expect_sig(3, 16'd1);
      if (c == 50) frame_begin = 1'b1;
      if (c == 51) begin
        expect_sig(0, 16'd10);
        expect_sig(1, 16'd10);
      end
      if (c == 83) expect_sig(3, 16'd0);
    end
    step();
    frame_begin = 1'b1;
    step();
    expect_pos(7'd30, 6'd20, 1'b0, 1'b0);

    // Reset mid-computation discards the partial result
    step();
    xpos = 12'd500;
    ypos = 12'd500;
    new_event = 1'b1;
    for (int c = 1; c <= 15; c++) step();
    rst_n = 1'b0;
    expect_pos(7'd0, 6'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) step();
    expect_sig(3, 16'd0);
    step();
    frame_begin = 1'b1;
    step();
    expect_pos(7'd0, 6'd0, 1'b0, 1'b0);

    // Drain and confirm every expectation was consumed
    for (int c = 0; c < 3; c++) step();
    n_tests++;
    if (sq.size() != 0 || pq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: status %0d pixel %0d entries, expected 0",
               sq.size(), pq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
